n2_dbus_arbiter: RTL and testbench
==================================

# n2_dbus_arbiter

Two-requester arbiter that shares the single data-memory port (req/gnt/ready protocol) between the core load/store unit (port 0) and a secondary master such as a DMA or debug engine (port 1). Sits between the LSU data interface and the data-memory/bus slave. It selects one requester per cycle and holds that selection stable while a request waits for grant. It tracks outstanding loads in an in-order ID FIFO so each `ready`/`rdata` beat returns to the requester that issued it.

## Interface
Parameters:
- `OUTSTD_DEPTH`, default 4: maximum outstanding loads (power of two, 2..16).

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `m0_req_i`, `m1_req_i`  in  1  request from port 0 (LSU) / port 1.
- `m0_we_i`, `m1_we_i`  in  1  1 = store, 0 = load.
- `m0_addr_i`, `m1_addr_i`  in  32  byte address.
- `m0_wdata_i`, `m1_wdata_i`  in  32  store data.
- `m0_wstrb_i`, `m1_wstrb_i`  in  4  byte strobes.
- `m0_gnt_o`, `m1_gnt_o`  out  1  request accepted this cycle.
- `m0_ready_o`, `m1_ready_o`  out  1  load data valid this cycle.
- `m0_rdata_o`, `m1_rdata_o`  out  32  load data; both driven from `s_rdata_i`.
- `s_req_o`, `s_we_o`, `s_addr_o`, `s_wdata_o`, `s_wstrb_o`  out  1/1/32/32/4  muxed request to memory.
- `s_gnt_i`  in  1  memory accepts `s_req_o`.
- `s_ready_i`  in  1  load response valid; in order, loads only.
- `s_rdata_i`  in  32  load response data.
- `err_o`  out  1  sticky: `s_ready_i` seen with no outstanding load.

## Operation
- `sel`: combinational owner of the slave port.
  - If `lock_q` is set, `sel = lock_id_q`.
  - Otherwise the sole requester wins.
  - If both request, the arbitration policy (see Configuration) decides.
- `s_req_o = (m0_req_i|m1_req_i) & ~full`.
- `s_we_o`, `s_addr_o`, `s_wdata_o`, `s_wstrb_o` are muxed from `sel`.
- `mX_gnt_o = s_gnt_i & s_req_o & (sel==X)`.
- Lock FSM, states IDLE and LOCKED:
  - IDLE → LOCKED when `s_req_o & ~s_gnt_i`; capture `lock_id_q = sel`.
  - LOCKED → IDLE on `s_gnt_i`.
  - While LOCKED, the other requester cannot steal the port. A locked requester must keep `req` asserted until granted.
- ID FIFO, `OUTSTD_DEPTH` entries of 1 bit:
  - Push `sel` on `s_gnt_i & s_req_o & ~s_we_o`.
  - Pop on `s_ready_i`.
  - Stores are never pushed and complete at grant.
- Response routing: `mX_ready_o = s_ready_i & ~empty & (head==X)`.
- `full` is asserted when count == `OUTSTD_DEPTH`. It masks `s_req_o` for both loads and stores so ordering stays simple.
- Simultaneous push and pop: count is unchanged and pointers advance. This cannot occur while full because no push happens when full.
- `s_ready_i` while empty: no `mX_ready_o`, no pop, and `err_o` is set until reset.
- Count is `$clog2(OUTSTD_DEPTH)+1` bits. Pointers wrap modulo `OUTSTD_DEPTH`.

## Timing
- Grant is zero-latency combinational from the `mX_req_i` and `s_gnt_i` inputs to `mX_gnt_o`. The arbiter adds no request-path register.
- Response is zero-latency: `s_ready_i` → `mX_ready_o` in the same cycle.
- Registered state: `lock_q`, `lock_id_q`, `rr_last_q`, FIFO pointers and count, `err_o`.
- Reset values:
  - All registered state is 0 and the FIFO is empty.
  - `err_o` = 0.
  - All `gnt`, `ready` and `s_req_o` outputs are 0 while no request is present.
- Reset mid-operation clears the lock and the FIFO. Responses arriving after reset for pre-reset loads set `err_o`.
- Back-to-back grants, one per cycle, are supported with no bubble.

## Configuration
- `N2_DBUS_RR_EN` defined:
  - Round-robin. On contention, the port other than `rr_last_q` wins.
  - `rr_last_q` updates to the granted port on every grant.
- Undefined:
  - Fixed priority, port 0 (LSU) always wins on contention.
  - `rr_last_q` is not implemented.

## Test plan
- Port 0 load to `0x100`, `s_gnt_i`=1; `s_ready_i` 2 cycles later with `rdata=0xDEADBEEF` → `m0_gnt_o` in cycle 0; `m0_ready_o`=1 with `m0_rdata_o=0xDEADBEEF`; `m1_ready_o`=0.
- Both request loads every cycle, `s_gnt_i`=1:
  - With RR: grants alternate 1,0,1,0 when the first cycle after reset picks port 1 (`rr_last_q`=0).
  - Without RR: port 0 gets every grant.
- Port 1 requests, `s_gnt_i`=0 for 3 cycles, port 0 raises `req` in cycle 1 → `s_addr_o` stays on port 1 through the grant cycle; port 0 is granted the following cycle.
- With `OUTSTD_DEPTH`=4, issue 4 loads with no `s_ready_i` → 5th request sees `s_req_o`=0. One `s_ready_i` → `s_req_o` reasserts the next cycle.
- Interleaved loads: port 0 at `0x0`, port 1 at `0x4`, then port 0 at `0x8`, followed by 3 `s_ready_i` → ready routed 0, 1, 0 in order. A store between them is not queued.
- `s_ready_i` with the FIFO empty → `err_o`=1 and stays 1. Assert `resetn`=0 mid-burst → FIFO empty and `err_o`=0.

Source files
------------

// File: rtl/n2_dbus_arbiter_if.sv
// rtl/n2_dbus_arbiter_if.sv - requester and data-memory signal bundle for n2_dbus_arbiter
interface n2_dbus_arbiter_if;
  logic        m0_req_i,   m1_req_i;
  logic        m0_we_i,    m1_we_i;
  logic [31:0] m0_addr_i,  m1_addr_i;
  logic [31:0] m0_wdata_i, m1_wdata_i;
  logic [3:0]  m0_wstrb_i, m1_wstrb_i;
  logic        m0_gnt_o,   m1_gnt_o;
  logic        m0_ready_o, m1_ready_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_wstrb_o;
  logic        s_gnt_i, s_ready_i;
  logic [31:0] s_rdata_i;

  // Arbiter view
  modport slave (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_addr_i, m1_addr_i,
           m0_wdata_i, m1_wdata_i, m0_wstrb_i, m1_wstrb_i,
           s_gnt_i, s_ready_i, s_rdata_i,
    output m0_gnt_o, m1_gnt_o, m0_ready_o, m1_ready_o, m0_rdata_o, m1_rdata_o,
           s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o
  );

  // Requesters plus memory, as seen from outside the arbiter
  modport master (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_addr_i, m1_addr_i,
           m0_wdata_i, m1_wdata_i, m0_wstrb_i, m1_wstrb_i,
           s_gnt_i, s_ready_i, s_rdata_i,
    input  m0_gnt_o, m1_gnt_o, m0_ready_o, m1_ready_o, m0_rdata_o, m1_rdata_o,
           s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o
  );
endinterface

// File: rtl/n2_dbus_arbiter.sv
// rtl/n2_dbus_arbiter.sv - two-port data-bus arbiter with request lock and in-order load ID FIFO
// Optional: define N2_DBUS_RR_EN for round-robin contention; default is fixed priority to port 0.
module n2_dbus_arbiter #(
  parameter int OUTSTD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  n2_dbus_arbiter_if.slave bus,
  output logic             err_o
);
  localparam int AW = $clog2(OUTSTD_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

  lock_state_t             r_state, w_state_nxt;
  logic                    r_lock_id, w_lock_id_nxt;
  logic [OUTSTD_DEPTH-1:0] r_id_fifo;
  logic [AW-1:0]           r_wptr, r_rptr;
  logic [CW-1:0]           r_count;
  logic                    r_err;
  logic                    w_sel, w_we, w_any, w_full, w_empty;
  logic                    w_s_req, w_grant, w_push, w_pop, w_head;
`ifdef N2_DBUS_RR_EN
  logic                    r_rr_last;
`endif

  assign w_any   = bus.m0_req_i | bus.m1_req_i;
  assign w_full  = (r_count == CW'(OUTSTD_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_id_fifo[r_rptr];

  // A refused request keeps the port so its address cannot change under the slave
  always_comb begin
    w_sel = bus.m1_req_i & ~bus.m0_req_i;
    if (r_state == ST_LOCKED) begin
      w_sel = r_lock_id;
    end else if (bus.m0_req_i & bus.m1_req_i) begin
`ifdef N2_DBUS_RR_EN
      w_sel = ~r_rr_last;
`else
      w_sel = 1'b0;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_we          = w_sel ? bus.m1_we_i : bus.m0_we_i;
    w_s_req       = w_any & ~w_full;
    w_grant       = bus.s_gnt_i & w_s_req;
    w_push        = w_grant & ~w_we;
    w_pop         = bus.s_ready_i & ~w_empty;
    case (r_state)
      ST_IDLE: begin
        if (w_s_req & ~bus.s_gnt_i) begin
          w_state_nxt   = ST_LOCKED;
          w_lock_id_nxt = w_sel;
        end
      end
      ST_LOCKED: begin
        if (bus.s_gnt_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.s_req_o    = w_s_req;
  assign bus.s_we_o     = w_we;
  assign bus.s_addr_o   = w_sel ? bus.m1_addr_i  : bus.m0_addr_i;
  assign bus.s_wdata_o  = w_sel ? bus.m1_wdata_i : bus.m0_wdata_i;
  assign bus.s_wstrb_o  = w_sel ? bus.m1_wstrb_i : bus.m0_wstrb_i;
  assign bus.m0_gnt_o   = w_grant & ~w_sel;
  assign bus.m1_gnt_o   = w_grant &  w_sel;
  assign bus.m0_ready_o = w_pop & ~w_head;
  assign bus.m1_ready_o = w_pop &  w_head;
  assign bus.m0_rdata_o = bus.s_rdata_i;
  assign bus.m1_rdata_o = bus.s_rdata_i;
  assign err_o          = r_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_lock_id <= 1'b0;
      r_id_fifo <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
`ifdef N2_DBUS_RR_EN
      r_rr_last <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      if (w_push) begin
        r_id_fifo[r_wptr] <= w_sel;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A response with nothing outstanding has no owner; flag it until reset
      if (bus.s_ready_i & w_empty) r_err <= 1'b1;
`ifdef N2_DBUS_RR_EN
      if (w_grant) r_rr_last <= w_sel;
`endif
    end
  end
endmodule

// File: tb/tb_n2_dbus_arbiter.sv
// tb/tb_n2_dbus_arbiter.sv - directed vector table, hand sequences and randomized model check
module tb_n2_dbus_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn;
  logic err_o;
  always #5 clk = ~clk;

  n2_dbus_arbiter_if bus ();
  n2_dbus_arbiter #(.OUTSTD_DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus), .err_o(err_o));

  typedef struct packed {
    logic g0, g1, r0, r1, sreq, swe, err;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic [3:0]  swstrb;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } obs_t;

  typedef struct {
    string       name;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr;
    logic        s_gnt, s_ready;
    logic [31:0] s_rdata;
    obs_t        exp;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[$];

  function automatic obs_t observe();
    obs_t o;
    o.g0 = bus.m0_gnt_o;     o.g1 = bus.m1_gnt_o;
    o.r0 = bus.m0_ready_o;   o.r1 = bus.m1_ready_o;
    o.sreq = bus.s_req_o;    o.swe = bus.s_we_o;   o.err = err_o;
    o.saddr = bus.s_addr_o;  o.swdata = bus.s_wdata_o; o.swstrb = bus.s_wstrb_o;
    o.rd0 = bus.m0_rdata_o;  o.rd1 = bus.m1_rdata_o;
    return o;
  endfunction

  // flags = {m0_gnt, m1_gnt, m0_ready, m1_ready, s_req, s_we, err}
  function automatic obs_t mkobs(input logic [6:0] f, input logic [31:0] a, input logic [31:0] rd);
    obs_t o;
    {o.g0, o.g1, o.r0, o.r1, o.sreq, o.swe, o.err} = f;
    o.saddr = a; o.swdata = '0; o.swstrb = '0; o.rd0 = rd; o.rd1 = rd;
    return o;
  endfunction

  function automatic vec_t mk(input string n,
                              input logic m0r, input logic m0w, input logic [31:0] m0a,
                              input logic m1r, input logic m1w, input logic [31:0] m1a,
                              input logic g, input logic r, input logic [31:0] rd,
                              input logic [6:0] f, input logic [31:0] sa);
    vec_t v;
    v.name = n; v.m0_req = m0r; v.m0_we = m0w; v.m0_addr = m0a;
    v.m1_req = m1r; v.m1_we = m1w; v.m1_addr = m1a;
    v.s_gnt = g; v.s_ready = r; v.s_rdata = rd;
    v.exp = mkobs(f, sa, rd);
    return v;
  endfunction

  task automatic check(input string name, input obs_t exp, input obs_t got);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_addr_i = '0; bus.m0_wdata_i = '0; bus.m0_wstrb_i = '0;
    bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0; bus.m1_wstrb_i = '0;
    bus.s_gnt_i = 0; bus.s_ready_i = 0; bus.s_rdata_i = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    drive_idle();
    bus.m0_req_i = v.m0_req; bus.m0_we_i = v.m0_we; bus.m0_addr_i = v.m0_addr;
    bus.m1_req_i = v.m1_req; bus.m1_we_i = v.m1_we; bus.m1_addr_i = v.m1_addr;
    bus.s_gnt_i = v.s_gnt; bus.s_ready_i = v.s_ready; bus.s_rdata_i = v.s_rdata;
  endtask

  // Inputs are applied 1 time unit after posedge; outputs are sampled on negedge
  task automatic step(input string name, input obs_t exp);
    @(negedge clk);
    check(name, exp, observe());
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive_idle();
    resetn = 0;
    @(posedge clk); @(posedge clk); #1;
    resetn = 1;
  endtask

  bit          pv[2];
  bit          pwe[2];
  logic [31:0] paddr[2], pwd[2];
  logic [3:0]  pws[2];
  bit          q[$];
  int          hold;
  bit          merr;
`ifdef N2_DBUS_RR_EN
  bit          last;
`endif

  initial begin
    bit owners[4];
    // load / response
    tbl.push_back(mk("ld0_grant",      1,0,32'h100, 0,0,0,      1,0,32'h0,        7'b1000100, 32'h100));
    tbl.push_back(mk("ld0_wait",       0,0,0,       0,0,0,      0,0,32'h0,        7'b0000000, 32'h0));
    tbl.push_back(mk("ld0_ready",      0,0,0,       0,0,0,      0,1,32'hDEADBEEF, 7'b0010000, 32'h0));
    // lock while port 1 waits for grant
    tbl.push_back(mk("lock_c0",        0,0,0,       1,0,32'h200,0,0,32'h0,        7'b0000100, 32'h200));
    tbl.push_back(mk("lock_c1",        1,0,32'h300, 1,0,32'h200,0,0,32'h0,        7'b0000100, 32'h200));
    tbl.push_back(mk("lock_c2",        1,0,32'h300, 1,0,32'h200,0,0,32'h0,        7'b0000100, 32'h200));
    tbl.push_back(mk("lock_grant1",    1,0,32'h300, 1,0,32'h200,1,0,32'h0,        7'b0100100, 32'h200));
    tbl.push_back(mk("lock_next0",     1,0,32'h300, 0,0,0,      1,0,32'h0,        7'b1000100, 32'h300));
    tbl.push_back(mk("lock_rdy1",      0,0,0,       0,0,0,      0,1,32'h11111111, 7'b0001000, 32'h0));
    tbl.push_back(mk("lock_rdy0",      0,0,0,       0,0,0,      0,1,32'h22222222, 7'b0010000, 32'h0));
    // fill the ID FIFO
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($sformatf("fill_%0d", i), 1,0,32'(32'h10 + 4*i), 0,0,0, 1,0,32'h0, 7'b1000100, 32'(32'h10 + 4*i)));
    tbl.push_back(mk("full_masked",    1,0,32'h20,  0,0,0,      1,0,32'h0,        7'b0000000, 32'h20));
    tbl.push_back(mk("full_pop",       1,0,32'h20,  0,0,0,      1,1,32'h33,       7'b0010000, 32'h20));
    tbl.push_back(mk("full_reassert",  1,0,32'h20,  0,0,0,      1,0,32'h0,        7'b1000100, 32'h20));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($sformatf("drain_%0d", i), 0,0,0, 0,0,0, 0,1,32'(32'h40 + i), 7'b0010000, 32'h0));
    // interleaved loads with a store in between
    tbl.push_back(mk("il_ld0",         1,0,32'h0,   0,0,0,      1,0,32'h0,        7'b1000100, 32'h0));
    tbl.push_back(mk("il_ld1",         0,0,0,       1,0,32'h4,  1,0,32'h0,        7'b0100100, 32'h4));
    tbl.push_back(mk("il_st1",         0,0,0,       1,1,32'hC,  1,0,32'h0,        7'b0100110, 32'hC));
    tbl.push_back(mk("il_ld0b",        1,0,32'h8,   0,0,0,      1,0,32'h0,        7'b1000100, 32'h8));
    tbl.push_back(mk("il_rdy_a",       0,0,0,       0,0,0,      0,1,32'hA0,       7'b0010000, 32'h0));
    tbl.push_back(mk("il_rdy_b",       0,0,0,       0,0,0,      0,1,32'hB0,       7'b0001000, 32'h0));
    tbl.push_back(mk("il_rdy_c",       0,0,0,       0,0,0,      0,1,32'hC0,       7'b0010000, 32'h0));
    // response with nothing outstanding
    tbl.push_back(mk("empty_rdy",      0,0,0,       0,0,0,      0,1,32'h55,       7'b0000000, 32'h0));
    tbl.push_back(mk("err_set",        0,0,0,       0,0,0,      0,0,32'h0,        7'b0000001, 32'h0));
    tbl.push_back(mk("err_sticky",     0,0,0,       0,0,0,      0,0,32'h0,        7'b0000001, 32'h0));

    drive_idle();
    resetn = 0;
    @(posedge clk); #1;
    check("reset_state", mkobs(7'b0, 32'h0, 32'h0), observe());
    @(posedge clk); #1;
    resetn = 1;

    foreach (tbl[i]) begin
      drive_vec(tbl[i]);
      step(tbl[i].name, tbl[i].exp);
    end

    // reset in the middle of outstanding loads
    drive_idle(); bus.m0_req_i = 1; bus.m0_addr_i = 32'h40; bus.s_gnt_i = 1;
    step("burst_a", mkobs(7'b1000101, 32'h40, 32'h0));
    bus.m0_addr_i = 32'h44;
    step("burst_b", mkobs(7'b1000101, 32'h44, 32'h0));
    drive_idle();
    resetn = 0;
    #1;
    check("async_reset", mkobs(7'b0, 32'h0, 32'h0), observe());
    @(posedge clk); #1;
    resetn = 1;
    step("post_reset_idle", mkobs(7'b0, 32'h0, 32'h0));
    bus.s_ready_i = 1; bus.s_rdata_i = 32'h77;
    step("stale_rdy_unrouted", mkobs(7'b0, 32'h0, 32'h77));
    drive_idle();
    step("stale_rdy_err", mkobs(7'b0000001, 32'h0, 32'h0));
    do_reset();

    // both ports request loads every cycle
    for (int i = 0; i < 4; i++) begin
`ifdef N2_DBUS_RR_EN
      owners[i] = (i % 2 == 0);
`else
      owners[i] = 1'b0;
`endif
      drive_idle();
      bus.m0_req_i = 1; bus.m0_addr_i = 32'h500;
      bus.m1_req_i = 1; bus.m1_addr_i = 32'h600;
      bus.s_gnt_i = 1;
      step($sformatf("contend_%0d", i),
           mkobs(owners[i] ? 7'b0100100 : 7'b1000100, owners[i] ? 32'h600 : 32'h500, 32'h0));
    end
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      bus.s_ready_i = 1; bus.s_rdata_i = 32'(32'hE0 + i);
      step($sformatf("contend_rdy_%0d", i),
           mkobs(owners[i] ? 7'b0001000 : 7'b0010000, 32'h0, 32'(32'hE0 + i)));
    end

    // randomized traffic against the reference model
    do_reset();
    q.delete(); hold = -1; merr = 0; pv[0] = 0; pv[1] = 0;
`ifdef N2_DBUS_RR_EN
    last = 0;
`endif
    for (int c = 0; c < 1500; c++) begin
      bit any, own, sreq, g, gnt, rdy;
      obs_t exp, got;
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) != 0) begin
          pv[p] = 1; pwe[p] = ($urandom_range(0, 3) == 0);
          paddr[p] = $urandom; pwd[p] = $urandom; pws[p] = 4'($urandom);
        end
      end
      gnt = ($urandom_range(0, 9) < 7);
      rdy = (q.size() > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
      bus.m0_req_i = pv[0]; bus.m0_we_i = pv[0] ? pwe[0] : 1'($urandom);
      bus.m0_addr_i = pv[0] ? paddr[0] : $urandom; bus.m0_wdata_i = pv[0] ? pwd[0] : $urandom;
      bus.m0_wstrb_i = pv[0] ? pws[0] : 4'($urandom);
      bus.m1_req_i = pv[1]; bus.m1_we_i = pv[1] ? pwe[1] : 1'($urandom);
      bus.m1_addr_i = pv[1] ? paddr[1] : $urandom; bus.m1_wdata_i = pv[1] ? pwd[1] : $urandom;
      bus.m1_wstrb_i = pv[1] ? pws[1] : 4'($urandom);
      bus.s_gnt_i = gnt; bus.s_ready_i = rdy; bus.s_rdata_i = $urandom;

      any = pv[0] | pv[1];
      if (hold >= 0) own = bit'(hold);
      else if (pv[0] && pv[1]) begin
`ifdef N2_DBUS_RR_EN
        own = ~last;
`else
        own = 1'b0;
`endif
      end else own = pv[1];
      sreq = any && (q.size() < DEPTH);
      g = gnt && sreq;

      @(negedge clk);
      exp.g0 = g && !own;   exp.g1 = g && own;
      exp.r0 = rdy && (q.size() > 0) && (q[0] == 1'b0);
      exp.r1 = rdy && (q.size() > 0) && (q[0] == 1'b1);
      exp.sreq = sreq; exp.err = merr;
      exp.swe = pwe[own]; exp.saddr = paddr[own]; exp.swdata = pwd[own]; exp.swstrb = pws[own];
      exp.rd0 = bus.s_rdata_i; exp.rd1 = bus.s_rdata_i;
      got = observe();
      if (!any) begin
        exp.swe = 0; exp.saddr = '0; exp.swdata = '0; exp.swstrb = '0;
        got.swe = 0; got.saddr = '0; got.swdata = '0; got.swstrb = '0;
      end
      check($sformatf("rand_%0d", c), exp, got);

      if (rdy) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1;
      end
      if (gnt) begin
        hold = -1;
        if (sreq) begin
          if (!pwe[own]) q.push_back(own);
          pv[own] = 0;
`ifdef N2_DBUS_RR_EN
          last = own;
`endif
        end
      end else if (sreq) begin
        hold = int'(own);
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
